avr_stack_engine: RTL and testbench
===================================

Name: avr_stack_engine

Overview:
Parametrised stack sequencer for the AVR core. It owns SP and runs the multi-byte memory sequences for PUSH, POP, CALL and RET. It replaces the per-instruction holdstate handling inside the CPU with one handshake-driven FSM. It supports 16-bit and 22-bit PCs, configurable stack bounds, and sticky overflow/underflow detection.

Parameters:
- PC_W, 16, return-address width; legal values 16 or 22. Derived: N_PC = ceil(PC_W/8), so 2 or 3 bytes.
- AW, 16, data-memory address width; SP is AW bits.
- SP_RESET, 16'h045F, SP value after reset (RAMEND).
- SP_LIMIT, 16'h0060, lowest legal stack address.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_op  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET
- cmd_ready  out  1  command accepted on the edge where cmd_valid&cmd_ready
- push_data  in  8  PUSH operand, sampled at accept
- call_pc  in  PC_W  return address, sampled at accept
- pop_data  out  8  POP result
- pop_valid  out  1  one-cycle pulse
- ret_pc  out  PC_W  RET result
- ret_valid  out  1  one-cycle pulse
- mem_addr  out  AW  data-memory address
- mem_wdata  out  8  write data
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_rdata  in  8  read data, valid the cycle after mem_re
- sp_wr_lo  in  1  software write of SPL
- sp_wr_hi  in  1  software write of SPH
- sp_wr_data  in  8  byte for the SP write
- sp  out  AW  current stack pointer
- busy  out  1  state != IDLE
- ovf  out  1  sticky overflow flag
- unf  out  1  sticky underflow flag
- flag_clr  in  1  clears ovf and unf

Behaviour:
- Reset values: SP=SP_RESET, state IDLE, cmd_ready=1, all strobes and valids 0, ovf=unf=0, pop_data=0, ret_pc=0, mem_addr=0, mem_wdata=0.
- RST mid-operation aborts the sequence: no strobe in the following cycle and no valid pulse.
- cmd_ready = (state==IDLE) & ~sp_wr_lo & ~sp_wr_hi.
- A software SP write always wins over a command in the same cycle; the command is held off.
- sp_wr_* arriving while busy is ignored.
- FSM states: IDLE, WRITE, READ, CAP, DONE.
- Accept: operands are registered and the byte counter cnt is cleared.
  - PUSH/CALL go to WRITE with N=1 or N=N_PC.
  - POP/RET go to READ with the same N.
- WRITE, one byte per cycle:
  - mem_addr=SP, mem_we=1, SP decrements at the end of the cycle.
  - CALL byte order is LSB first, so memory holds [SP0]=PC[7:0], [SP0-1]=PC[15:8], [SP0-2]=PC[21:16].
  - After the Nth byte go to IDLE.
  - Busy time: PUSH 1 cycle, CALL N_PC cycles.
- READ, N cycles:
  - mem_re=1, mem_addr = SP+1+k for k = 0..N-1. RET therefore reads the MSB first.
  - mem_rdata for byte k-1 is captured in READ cycle k.
  - After the last READ go to CAP, which captures the final byte, then go to DONE.
- DONE, one cycle:
  - pop_valid or ret_valid is high with the assembled value.
  - SP += N at the end of the cycle, then go to IDLE.
  - POP latency is 3 cycles from accept to valid; RET (N=2) latency is 4.
- Overflow: a write with SP < SP_LIMIT has mem_we suppressed and sets ovf. SP still decrements.
- Underflow: a read issued at an address > SP_RESET sets unf. The read is still performed and data is returned.
- flag_clr clears both flags. If a set event and flag_clr occur in the same cycle, set wins.
- SP arithmetic is modulo 2^AW. sp_wr_hi writes SP[AW-1:8]; bits above 15 are ignored.
- Unused bits of ret_pc above PC_W do not exist; no padding.

Decomposition:
- Package avr_stack_pkg holds:
  - cmd_op encodings as localparams OP_PUSH, OP_POP, OP_CALL, OP_RET;
  - the FSM state encoding;
  - the N_PC function.
- One sub-module, avr_sp_reg, holds SP with:
  - byte-write ports;
  - decrement-by-1 and add-N controls;
  - reset to SP_RESET.

Test Plan (PC_W=16 unless noted):
1. RST for 2 cycles -> sp=0x045F, cmd_ready=1, mem_we=mem_re=0, ovf=unf=0.
2. PUSH 0xA5, then POP:
   - PUSH -> one mem_we at 0x045F with data 0xA5, sp=0x045E.
   - POP -> mem_re at 0x045F, pop_valid 3 cycles after accept with pop_data=0xA5, sp=0x045F.
3. CALL 0x1234, then RET:
   - CALL -> writes 0x34@0x045F and 0x12@0x045E, sp=0x045D.
   - RET -> reads 0x045E then 0x045F, ret_pc=0x1234, sp=0x045F.
4. PC_W=22, CALL 0x2ABCDE, then RET:
   - CALL -> 0xDE@045F, 0xBC@045E, 0x2A@045D, sp=0x045C.
   - RET -> ret_pc=0x2ABCDE.
5. sp_wr_hi=0x00 and sp_wr_lo=0x60, then PUSH twice, then flag_clr:
   - first PUSH -> write occurs, sp=0x005F;
   - second PUSH -> mem_we stays 0, ovf=1, sp=0x005E;
   - flag_clr -> ovf=0.
6. Boundary cases:
   - POP at sp=0x045F -> unf=1.
   - cmd_valid together with sp_wr_lo -> cmd_ready=0 and SPL updated.
   - RST during the second CALL byte -> no further mem_we and sp=0x045F.

Source files
------------

// File: rtl/avr_stack_pkg.sv
// rtl/avr_stack_pkg.sv - shared opcodes, FSM states and PC byte-count helper for the stack engine
package avr_stack_pkg;
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CAP,
    ST_DONE
  } state_t;

  function automatic int n_pc(input int pc_w);
    return (pc_w + 7) / 8;
  endfunction
endpackage

// File: rtl/avr_stack_engine_if.sv
// rtl/avr_stack_engine_if.sv - command, result, memory and SP-access signals of the stack engine
interface avr_stack_engine_if #(
  parameter int PC_W = 16,
  parameter int AW   = 16
);
  logic            cmd_valid;
  logic [1:0]      cmd_op;
  logic            cmd_ready;
  logic [7:0]      push_data;
  logic [PC_W-1:0] call_pc;
  logic [7:0]      pop_data;
  logic            pop_valid;
  logic [PC_W-1:0] ret_pc;
  logic            ret_valid;
  logic [AW-1:0]   mem_addr;
  logic [7:0]      mem_wdata;
  logic            mem_we;
  logic            mem_re;
  logic [7:0]      mem_rdata;
  logic            sp_wr_lo;
  logic            sp_wr_hi;
  logic [7:0]      sp_wr_data;
  logic [AW-1:0]   sp;
  logic            busy;
  logic            ovf;
  logic            unf;
  logic            flag_clr;

  modport slave (
    input  cmd_valid, cmd_op, push_data, call_pc, mem_rdata,
           sp_wr_lo, sp_wr_hi, sp_wr_data, flag_clr,
    output cmd_ready, pop_data, pop_valid, ret_pc, ret_valid,
           mem_addr, mem_wdata, mem_we, mem_re, sp, busy, ovf, unf
  );

  modport master (
    output cmd_valid, cmd_op, push_data, call_pc, mem_rdata,
           sp_wr_lo, sp_wr_hi, sp_wr_data, flag_clr,
    input  cmd_ready, pop_data, pop_valid, ret_pc, ret_valid,
           mem_addr, mem_wdata, mem_we, mem_re, sp, busy, ovf, unf
  );
endinterface

// File: rtl/avr_sp_reg.sv
// rtl/avr_sp_reg.sv - stack pointer register with byte writes, decrement and add-N
module avr_sp_reg #(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] SP_RESET = 16'h045F
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_lo,
  input  logic          wr_hi,
  input  logic [7:0]    wr_data,
  input  logic          dec,
  input  logic          add,
  input  logic [1:0]    add_n,
  output logic [AW-1:0] sp
);
  logic [AW-1:0] sp_nx;

  // Byte writes and the FSM adjustments never coincide: writes are only passed through while idle.
  always_comb begin
    sp_nx = sp;
    if (wr_lo) sp_nx = (sp_nx & ~AW'(8'hFF)) | AW'(wr_data);
    if (wr_hi) sp_nx = (sp_nx & ~(AW'(8'hFF) << 8)) | (AW'(wr_data) << 8);
    if (dec)
      sp_nx = sp - AW'(1);
    else if (add)
      sp_nx = sp + AW'(add_n);
  end

  always_ff @(posedge CLK) begin
    if (RST) sp <= SP_RESET;
    else     sp <= sp_nx;
  end
endmodule

// File: rtl/avr_stack_engine.sv
// rtl/avr_stack_engine.sv - SP owner and PUSH/POP/CALL/RET memory sequencer
module avr_stack_engine
  import avr_stack_pkg::*;
#(
  parameter int            PC_W     = 16,
  parameter int            AW       = 16,
  parameter logic [AW-1:0] SP_RESET = 16'h045F,
  parameter logic [AW-1:0] SP_LIMIT = 16'h0060
) (
  input logic                 CLK,
  input logic                 RST,
  avr_stack_engine_if.slave   bus
);
  localparam int N_PC = n_pc(PC_W);
  localparam int DW   = N_PC * 8;

  state_t        state;
  logic [1:0]    op_q;
  logic [1:0]    n_q;
  logic [1:0]    cnt;
  logic [DW-1:0] data_sr;
  logic [DW-9:0] acc;
  logic [DW-1:0] acc_nx;
  logic [DW-1:0] op_word;
  logic [1:0]    cmd_n;
  logic          cmd_wr;
  logic          idle;
  logic [AW-1:0] sp;
  logic          ovf_q;
  logic          unf_q;

  assign idle          = (state == ST_IDLE);
  assign bus.cmd_ready = idle & ~bus.sp_wr_lo & ~bus.sp_wr_hi;
  assign bus.busy      = ~idle;
  assign bus.sp        = sp;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

  assign cmd_wr  = (bus.cmd_op == OP_PUSH) || (bus.cmd_op == OP_CALL);
  assign cmd_n   = ((bus.cmd_op == OP_CALL) || (bus.cmd_op == OP_RET)) ? 2'(N_PC) : 2'd1;
  assign op_word = (bus.cmd_op == OP_PUSH) ? DW'(bus.push_data) : DW'(bus.call_pc);
  // Bytes arrive MSB first, so shifting left leaves the final byte in the low lane.
  assign acc_nx  = {acc, bus.mem_rdata};

  avr_sp_reg #(.AW(AW), .SP_RESET(SP_RESET)) u_sp (
    .CLK     (CLK),
    .RST     (RST),
    .wr_lo   (bus.sp_wr_lo & idle),
    .wr_hi   (bus.sp_wr_hi & idle),
    .wr_data (bus.sp_wr_data),
    .dec     (state == ST_WRITE),
    .add     (state == ST_DONE),
    .add_n   (n_q),
    .sp      (sp)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ((state == ST_WRITE) && (sp < SP_LIMIT)) | (ovf_q & ~bus.flag_clr);
      unf_q <= ((state == ST_READ) && (bus.mem_addr > SP_RESET)) | (unf_q & ~bus.flag_clr);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_IDLE;
      op_q          <= '0;
      n_q           <= '0;
      cnt           <= '0;
      data_sr       <= '0;
      acc           <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.pop_data  <= '0;
      bus.pop_valid <= 1'b0;
      bus.ret_pc    <= '0;
      bus.ret_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            op_q <= bus.cmd_op;
            n_q  <= cmd_n;
            cnt  <= '0;
            acc  <= '0;
            if (cmd_wr) begin
              state         <= ST_WRITE;
              data_sr       <= op_word >> 8;
              bus.mem_wdata <= op_word[7:0];
              bus.mem_addr  <= sp;
              bus.mem_we    <= (sp >= SP_LIMIT);
            end else begin
              state        <= ST_READ;
              bus.mem_addr <= sp + AW'(1);
              bus.mem_re   <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (cnt == n_q - 2'd1) begin
            state      <= ST_IDLE;
            bus.mem_we <= 1'b0;
          end else begin
            cnt           <= cnt + 2'd1;
            bus.mem_addr  <= sp - AW'(1);
            bus.mem_wdata <= data_sr[7:0];
            data_sr       <= data_sr >> 8;
            bus.mem_we    <= ((sp - AW'(1)) >= SP_LIMIT);
          end
        end
        ST_READ: begin
          // Read data trails the strobe by a cycle, so cycle k captures byte k-1.
          if (cnt != 2'd0) acc <= acc_nx[DW-9:0];
          if (cnt == n_q - 2'd1) begin
            state      <= ST_CAP;
            bus.mem_re <= 1'b0;
          end else begin
            cnt          <= cnt + 2'd1;
            bus.mem_addr <= bus.mem_addr + AW'(1);
          end
        end
        ST_CAP: begin
          state <= ST_DONE;
          if (op_q == OP_POP) begin
            bus.pop_data  <= acc_nx[7:0];
            bus.pop_valid <= 1'b1;
          end else begin
            bus.ret_pc    <= acc_nx[PC_W-1:0];
            bus.ret_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          state         <= ST_IDLE;
          bus.pop_valid <= 1'b0;
          bus.ret_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avr_stack_engine.sv
// tb/tb_avr_stack_engine.sv - directed self-checking bench for avr_stack_engine (16- and 22-bit PC)
module tb_avr_stack_engine;
  import avr_stack_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  avr_stack_engine_if #(.PC_W(16), .AW(16)) b16 ();
  avr_stack_engine_if #(.PC_W(22), .AW(16)) b22 ();

  avr_stack_engine #(.PC_W(16)) dut16 (.CLK(CLK), .RST(RST), .bus(b16.slave));
  avr_stack_engine #(.PC_W(22)) dut22 (.CLK(CLK), .RST(RST), .bus(b22.slave));

  logic [7:0] m16 [0:4095];
  logic [7:0] m22 [0:4095];

  always @(posedge CLK) begin
    if (b16.mem_we) m16[b16.mem_addr[11:0]] <= b16.mem_wdata;
    if (b16.mem_re) b16.mem_rdata <= m16[b16.mem_addr[11:0]];
    if (b22.mem_we) m22[b22.mem_addr[11:0]] <= b22.mem_wdata;
    if (b22.mem_re) b22.mem_rdata <= m22[b22.mem_addr[11:0]];
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    b16.cmd_valid = 0; b16.cmd_op = OP_PUSH; b16.push_data = 0; b16.call_pc = 0;
    b16.sp_wr_lo = 0; b16.sp_wr_hi = 0; b16.sp_wr_data = 0; b16.flag_clr = 0;
    b22.cmd_valid = 0; b22.cmd_op = OP_PUSH; b22.push_data = 0; b22.call_pc = 0;
    b22.sp_wr_lo = 0; b22.sp_wr_hi = 0; b22.sp_wr_data = 0; b22.flag_clr = 0;

    // reset
    RST = 1; tick; tick; RST = 0;
    chk("rst_sp", b16.sp, 32'h045F);
    chk("rst_ready", b16.cmd_ready, 1);
    chk("rst_we", b16.mem_we, 0);
    chk("rst_re", b16.mem_re, 0);
    chk("rst_ovf", b16.ovf, 0);
    chk("rst_unf", b16.unf, 0);
    chk("rst_busy", b16.busy, 0);
    chk("rst_sp22", b22.sp, 32'h045F);

    // PUSH 0xA5
    b16.cmd_valid = 1; b16.cmd_op = OP_PUSH; b16.push_data = 8'hA5;
    tick; b16.cmd_valid = 0;
    chk("push_we", b16.mem_we, 1);
    chk("push_addr", b16.mem_addr, 32'h045F);
    chk("push_data", b16.mem_wdata, 32'hA5);
    chk("push_busy", b16.busy, 1);
    tick;
    chk("push_sp", b16.sp, 32'h045E);
    chk("push_we_end", b16.mem_we, 0);
    chk("push_idle", b16.busy, 0);

    // POP
    b16.cmd_valid = 1; b16.cmd_op = OP_POP;
    tick; b16.cmd_valid = 0;
    chk("pop_re", b16.mem_re, 1);
    chk("pop_addr", b16.mem_addr, 32'h045F);
    tick;
    chk("pop_valid_c2", b16.pop_valid, 0);
    tick;
    chk("pop_valid_c3", b16.pop_valid, 1);
    chk("pop_data", b16.pop_data, 32'hA5);
    tick;
    chk("pop_valid_off", b16.pop_valid, 0);
    chk("pop_sp", b16.sp, 32'h045F);
    chk("pop_unf", b16.unf, 0);

    // CALL 0x1234
    b16.cmd_valid = 1; b16.cmd_op = OP_CALL; b16.call_pc = 16'h1234;
    tick; b16.cmd_valid = 0;
    chk("call_b0_addr", b16.mem_addr, 32'h045F);
    chk("call_b0_data", b16.mem_wdata, 32'h34);
    chk("call_b0_we", b16.mem_we, 1);
    tick;
    chk("call_b1_addr", b16.mem_addr, 32'h045E);
    chk("call_b1_data", b16.mem_wdata, 32'h12);
    chk("call_b1_we", b16.mem_we, 1);
    tick;
    chk("call_sp", b16.sp, 32'h045D);
    chk("call_we_end", b16.mem_we, 0);

    // RET
    b16.cmd_valid = 1; b16.cmd_op = OP_RET;
    tick; b16.cmd_valid = 0;
    chk("ret_r0_addr", b16.mem_addr, 32'h045E);
    chk("ret_r0_re", b16.mem_re, 1);
    tick;
    chk("ret_r1_addr", b16.mem_addr, 32'h045F);
    tick;
    chk("ret_cap_valid", b16.ret_valid, 0);
    tick;
    chk("ret_valid", b16.ret_valid, 1);
    chk("ret_pc", b16.ret_pc, 32'h1234);
    tick;
    chk("ret_sp", b16.sp, 32'h045F);
    chk("ret_valid_off", b16.ret_valid, 0);

    // 22-bit CALL 0x2ABCDE / RET
    b22.cmd_valid = 1; b22.cmd_op = OP_CALL; b22.call_pc = 22'h2ABCDE;
    tick; b22.cmd_valid = 0;
    chk("c22_b0", {b22.mem_addr, b22.mem_wdata}, 32'h045FDE);
    tick;
    chk("c22_b1", {b22.mem_addr, b22.mem_wdata}, 32'h045EBC);
    tick;
    chk("c22_b2", {b22.mem_addr, b22.mem_wdata}, 32'h045D2A);
    chk("c22_b2_we", b22.mem_we, 1);
    tick;
    chk("c22_sp", b22.sp, 32'h045C);
    b22.cmd_valid = 1; b22.cmd_op = OP_RET;
    tick; b22.cmd_valid = 0;
    chk("r22_r0_addr", b22.mem_addr, 32'h045D);
    tick; tick; tick;
    chk("r22_cap_valid", b22.ret_valid, 0);
    tick;
    chk("r22_valid", b22.ret_valid, 1);
    chk("r22_pc", b22.ret_pc, 32'h2ABCDE);
    tick;
    chk("r22_sp", b22.sp, 32'h045F);

    // SP writes, SP write beats command, overflow
    b16.sp_wr_hi = 1; b16.sp_wr_data = 8'h00;
    tick; b16.sp_wr_hi = 0;
    chk("sph_write", b16.sp, 32'h005F);
    b16.sp_wr_lo = 1; b16.sp_wr_data = 8'h60;
    b16.cmd_valid = 1; b16.cmd_op = OP_PUSH; b16.push_data = 8'h11;
    #1;
    chk("spw_blocks_ready", b16.cmd_ready, 0);
    tick; b16.sp_wr_lo = 0; b16.cmd_valid = 0;
    chk("spl_write", b16.sp, 32'h0060);
    chk("spw_cmd_held", b16.busy, 0);
    b16.cmd_valid = 1;
    tick; b16.cmd_valid = 0;
    chk("lim_push_we", b16.mem_we, 1);
    chk("lim_push_addr", b16.mem_addr, 32'h0060);
    tick;
    chk("lim_push_sp", b16.sp, 32'h005F);
    chk("lim_push_ovf", b16.ovf, 0);
    b16.cmd_valid = 1; b16.push_data = 8'h22;
    tick; b16.cmd_valid = 0;
    chk("ovf_push_we", b16.mem_we, 0);
    chk("ovf_push_busy", b16.busy, 1);
    tick;
    chk("ovf_set", b16.ovf, 1);
    chk("ovf_sp", b16.sp, 32'h005E);
    b16.flag_clr = 1;
    tick; b16.flag_clr = 0;
    chk("ovf_clr", b16.ovf, 0);

    // underflow, SP write ignored while busy
    b16.sp_wr_hi = 1; b16.sp_wr_lo = 1; b16.sp_wr_data = 8'h04;
    #1;
    b16.sp_wr_hi = 1; b16.sp_wr_lo = 0;
    tick; b16.sp_wr_hi = 0;
    b16.sp_wr_lo = 1; b16.sp_wr_data = 8'h5F;
    tick; b16.sp_wr_lo = 0;
    chk("sp_restore", b16.sp, 32'h045F);
    b16.cmd_valid = 1; b16.cmd_op = OP_POP;
    tick; b16.cmd_valid = 0;
    chk("unf_addr", b16.mem_addr, 32'h0460);
    b16.sp_wr_lo = 1; b16.sp_wr_data = 8'h00;
    tick; b16.sp_wr_lo = 0;
    chk("unf_set", b16.unf, 1);
    tick;
    chk("unf_pop_valid", b16.pop_valid, 1);
    tick;
    chk("busy_spw_ignored", b16.sp, 32'h0460);

    // reset during second CALL byte
    b16.cmd_valid = 1; b16.cmd_op = OP_CALL; b16.call_pc = 16'h5678;
    tick; b16.cmd_valid = 0;
    chk("abort_b0_addr", b16.mem_addr, 32'h0460);
    tick;
    chk("abort_b1_we", b16.mem_we, 1);
    chk("abort_b1_addr", b16.mem_addr, 32'h045F);
    RST = 1;
    tick; RST = 0;
    chk("abort_we", b16.mem_we, 0);
    chk("abort_sp", b16.sp, 32'h045F);
    chk("abort_busy", b16.busy, 0);
    chk("abort_unf", b16.unf, 0);
    tick;
    chk("abort_we_after", b16.mem_we, 0);
    chk("abort_ret_valid", b16.ret_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
